// File: rtl/approx_error_monitor.sv
// Error-metric engine for W x W approximate multipliers: accumulates error count,
// signed/absolute error distance, max error distance and fixed-point relative error.
module approx_error_monitor #(
    parameter int W           = 8,
    parameter int CNT_W       = 16,
    parameter int RE_FRAC     = 16,
    parameter int NUM_SAMPLES = 10000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [W-1:0]                     a,
    input  logic [W-1:0]                     b,
    input  logic [2*W-1:0]                   p_apprx,
    output logic                             busy,
    output logic                             done,
    output logic [CNT_W-1:0]                 sample_count,
    output logic [CNT_W-1:0]                 err_count,
    output logic signed [2*W+CNT_W:0]        sum_ed,
    output logic [2*W+CNT_W-1:0]             sum_ed_abs,
    output logic [2*W-1:0]                   max_ed,
    output logic [2*W+RE_FRAC+CNT_W-1:0]     sum_re
);

    localparam int PW    = 2*W;
    localparam int N     = PW + RE_FRAC;
    localparam int ED_W  = PW + CNT_W + 1;
    localparam int RE_W  = PW + RE_FRAC + CNT_W;
    localparam int ABS_W = PW + CNT_W;
    localparam int IW    = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(NUM_SAMPLES);
    localparam logic [IW-1:0]    LAST_ITER   = IW'(N-1);

    typedef enum logic [2:0] {IDLE, RUN, CALC, DIV, DONE} state_t;
    state_t state, state_next;

    logic [W-1:0]     a_r, b_r;
    logic [PW-1:0]    p_r;
    logic [N-1:0]     dvd, quo, quo_next;
    logic [PW-1:0]    dsr, rem, rem_sub;
    logic [IW-1:0]    iter;
    logic [PW:0]      trial;
    logic             q_bit;
    logic [PW-1:0]    exact, ed_abs;
    logic [ED_W-1:0]  ed_delta;
    logic [CNT_W-1:0] count_inc;
    logic             in_ready_d, busy_d, done_d;

    always_comb begin
        exact     = PW'(a_r) * PW'(b_r);
        ed_abs    = (exact >= p_r) ? exact - p_r : p_r - exact;
        ed_delta  = ED_W'(exact) - ED_W'(p_r);
        count_inc = sample_count + CNT_W'(1);
        // Restoring step: remainder always < divisor, so it fits in PW bits.
        trial     = {rem, dvd[N-1]};
        q_bit     = (trial >= {1'b0, dsr});
        rem_sub   = trial[PW-1:0] - dsr;
        quo_next  = {quo[N-2:0], q_bit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= in_ready_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (in_valid && in_ready) state_next = CALC;
            CALC: begin
                if (exact == '0 || ed_abs == '0)
                    state_next = (count_inc == LAST_SAMPLE) ? DONE : RUN;
                else
                    state_next = DIV;
            end
            DIV: begin
                if (iter == LAST_ITER)
                    state_next = (sample_count == LAST_SAMPLE) ? DONE : RUN;
            end
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_d = (state_next == RUN);
        busy_d     = (state_next == RUN) || (state_next == CALC) || (state_next == DIV);
        done_d     = (state_next == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r          <= '0;
            b_r          <= '0;
            p_r          <= '0;
            dvd          <= '0;
            dsr          <= '0;
            rem          <= '0;
            quo          <= '0;
            iter         <= '0;
            sample_count <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            sum_ed_abs   <= '0;
            max_ed       <= '0;
            sum_re       <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sample_count <= '0;
                        err_count    <= '0;
                        sum_ed       <= '0;
                        sum_ed_abs   <= '0;
                        max_ed       <= '0;
                        sum_re       <= '0;
                    end
                end
                RUN: begin
                    if (in_valid && in_ready) begin
                        a_r <= a;
                        b_r <= b;
                        p_r <= p_apprx;
                    end
                end
                CALC: begin
                    sum_ed       <= sum_ed + $signed(ed_delta);
                    sum_ed_abs   <= sum_ed_abs + ABS_W'(ed_abs);
                    sample_count <= count_inc;
                    if (ed_abs != '0) err_count <= err_count + CNT_W'(1);
                    if (ed_abs > max_ed) max_ed <= ed_abs;
                    dvd  <= {ed_abs, {RE_FRAC{1'b0}}};
                    dsr  <= exact;
                    rem  <= '0;
                    quo  <= '0;
                    iter <= '0;
                end
                DIV: begin
                    dvd  <= {dvd[N-2:0], 1'b0};
                    rem  <= q_bit ? rem_sub : trial[PW-1:0];
                    quo  <= quo_next;
                    iter <= iter + IW'(1);
                    if (iter == LAST_ITER) sum_re <= sum_re + RE_W'(quo_next);
                end
                default: ;
            endcase
        end
    end

endmodule
